// File: rtl/int_div_lane_seq_pkg.sv
// rtl/int_div_lane_seq_pkg.sv - shared SFU divider front-end constants and types
// Purpose: lane geometry, FSM state encoding and the per-lane vector type.
// Ports: none (package).
package int_div_lane_seq_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_THREAD = 8;
  localparam int LANE_W     = $clog2(NUM_THREAD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Lane k occupies bits [k*XLEN +: XLEN], matching the flat bus packing.
  typedef logic [NUM_THREAD-1:0][XLEN-1:0] lane_vec_t;

endpackage

// File: rtl/int_div_lane_seq_if.sv
// rtl/int_div_lane_seq_if.sv - request, scalar-divider and result handshakes
// Purpose: bundles the vector request, the divider operand/result channels and
// the vector result channel.
// Ports: slave = the lane sequencer side, master = issue stage / divider / consumer side.
interface int_div_lane_seq_if;
  import int_div_lane_seq_pkg::*;

  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [NUM_THREAD*XLEN-1:0] a_i;
  logic [NUM_THREAD*XLEN-1:0] d_i;
  logic [NUM_THREAD-1:0]      mask_i;
  logic                       sign_i;
  logic                       rem_i;

  logic                       div_valid_o;
  logic                       div_ready_i;
  logic [XLEN-1:0]            div_a_o;
  logic [XLEN-1:0]            div_d_o;
  logic                       div_sign_o;

  logic                       div_out_valid_i;
  logic                       div_out_ready_o;
  logic [XLEN-1:0]            div_q_i;
  logic [XLEN-1:0]            div_r_i;

  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [NUM_THREAD*XLEN-1:0] out_data_o;
  logic [NUM_THREAD-1:0]      out_mask_o;

  modport slave (
    input  in_valid_i, a_i, d_i, mask_i, sign_i, rem_i,
    output in_ready_o,
    output div_valid_o, div_a_o, div_d_o, div_sign_o,
    input  div_ready_i,
    input  div_out_valid_i, div_q_i, div_r_i,
    output div_out_ready_o,
    output out_valid_o, out_data_o, out_mask_o,
    input  out_ready_i
  );

  modport master (
    output in_valid_i, a_i, d_i, mask_i, sign_i, rem_i,
    input  in_ready_o,
    input  div_valid_o, div_a_o, div_d_o, div_sign_o,
    output div_ready_i,
    output div_out_valid_i, div_q_i, div_r_i,
    input  div_out_ready_o,
    input  out_valid_o, out_data_o, out_mask_o,
    output out_ready_i
  );

endinterface

// File: rtl/int_div_lane_seq_lane_prio_enc.sv
// rtl/int_div_lane_seq_lane_prio_enc.sv - lowest-set-bit lane encoder
// Purpose: picks the lowest pending lane.
// Ports: i_vec (N) request bits; o_idx (W) index of lowest set bit; o_any set when any bit is set.
module lane_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_vec[k]) begin
        o_idx = W'(k);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_div_lane_seq.sv
// rtl/int_div_lane_seq.sv - serialises a masked vector divide onto one scalar divider
// Purpose: accepts a vector request, issues active lanes lowest-first to the
// divider one at a time, gathers quotient or remainder per lane, returns the vector.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the request,
// divider operand/result and vector result handshakes.
module int_div_lane_seq
  import int_div_lane_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  int_div_lane_seq_if.slave   bus
);

  state_e                r_state;
  lane_vec_t             r_a_buf;
  lane_vec_t             r_d_buf;
  lane_vec_t             r_res_buf;
  logic [NUM_THREAD-1:0] r_pend;
  logic [NUM_THREAD-1:0] r_mask;
  logic                  r_sign;
  logic                  r_rem;
  logic [LANE_W-1:0]     r_cur_lane;
  logic                  r_in_ready;
  logic                  r_div_valid;
  logic                  r_div_out_ready;
  logic                  r_out_valid;

  logic [LANE_W-1:0]     w_lane;
  logic                  w_any;
  logic [NUM_THREAD-1:0] w_pend_clr;
  logic                  w_issue;

  lane_prio_enc #(.N(NUM_THREAD), .W(LANE_W)) u_lane_prio_enc (
    .i_vec (r_pend),
    .o_idx (w_lane),
    .o_any (w_any)
  );

  // Pending set once the lane currently in the divider has returned.
  assign w_pend_clr = r_pend & ~(NUM_THREAD'(1) << r_cur_lane);

  // Operands are shown only while offering; pend is untouched in ISSUE so they hold.
  assign w_issue = r_div_valid & w_any;

  assign bus.in_ready_o      = r_in_ready;
  assign bus.div_valid_o     = r_div_valid;
  assign bus.div_a_o         = w_issue ? r_a_buf[w_lane] : '0;
  assign bus.div_d_o         = w_issue ? r_d_buf[w_lane] : '0;
  assign bus.div_sign_o      = r_sign;
  assign bus.div_out_ready_o = r_div_out_ready;
  assign bus.out_valid_o     = r_out_valid;
  assign bus.out_data_o      = r_res_buf;
  assign bus.out_mask_o      = r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_a_buf         <= '0;
      r_d_buf         <= '0;
      r_res_buf       <= '0;
      r_pend          <= '0;
      r_mask          <= '0;
      r_sign          <= 1'b0;
      r_rem           <= 1'b0;
      r_cur_lane      <= '0;
      r_in_ready      <= 1'b1;
      r_div_valid     <= 1'b0;
      r_div_out_ready <= 1'b0;
      r_out_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            r_a_buf    <= bus.a_i;
            r_d_buf    <= bus.d_i;
            r_mask     <= bus.mask_i;
            r_pend     <= bus.mask_i;
            r_sign     <= bus.sign_i;
            r_rem      <= bus.rem_i;
            r_res_buf  <= '0;
            r_in_ready <= 1'b0;
            if (bus.mask_i == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_div_valid <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.div_ready_i) begin
            r_cur_lane      <= w_lane;
            r_div_valid     <= 1'b0;
            r_div_out_ready <= 1'b1;
            r_state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.div_out_valid_i) begin
            r_res_buf[r_cur_lane] <= r_rem ? bus.div_r_i : bus.div_q_i;
            r_pend                <= w_pend_clr;
            r_div_out_ready       <= 1'b0;
            if (w_pend_clr == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_div_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
